// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART download loader: FSM encodings,
// response bytes, UART receive-register field positions and the checksum helper.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_DATA = 3'd2,
    ST_MEMW = 3'd3,
    ST_SUM  = 3'd4,
    ST_RESP = 3'd5,
    ST_GO   = 3'd6
  } ld_state_e;

  typedef enum logic [1:0] {
    PS_IDLE   = 2'd0,
    PS_REQ    = 2'd1,
    PS_SAMPLE = 2'd2
  } poll_state_e;

  localparam logic [7:0] RESP_OK  = 8'h4B;
  localparam logic [7:0] RESP_ERR = 8'h45;
  localparam logic [7:0] RESP_TO  = 8'h54;

  localparam int RX_FLAG_BIT = 15;
  localparam int RX_BYTE_MSB = 7;
  localparam int RX_BYTE_LSB = 0;

  function automatic logic [7:0] sum8(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/uart_loader_if.sv
// Bus interfaces of the loader: UART register port and memory write port.
interface loader_uart_if;
  logic        uart_valid;
  logic        uart_wmask;
  logic [31:0] uart_wdata;
  logic        uart_ready;
  logic [31:0] uart_rdata;

  modport master (output uart_valid, uart_wmask, uart_wdata, input uart_ready, uart_rdata);
  modport slave  (input uart_valid, uart_wmask, uart_wdata, output uart_ready, uart_rdata);
endinterface

interface loader_mem_if;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;

  modport master (output mem_valid, mem_addr, mem_wdata, mem_wstrb, input mem_ready);
  modport slave  (input mem_valid, mem_addr, mem_wdata, mem_wstrb, output mem_ready);
endinterface

// File: rtl/uart_loader_byte_poller.sv
// Two-cycle UART receive poll (request, then sample) plus the inter-byte
// timeout counter. Delivers one byte per byte_valid pulse.
module uart_byte_poller
  import loader_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int TO_W           = 20
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       tmo_en,
  input  logic       rx_flag,
  input  logic [7:0] rx_data,
  output logic       poll_valid,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       timeout,
  output logic       idle
);

  poll_state_e     state_q, state_d;
  logic            valid_q, valid_d;
  logic [7:0]      byte_q, byte_d;
  logic            bv_q, bv_d;
  logic            to_q, to_d;
  logic [TO_W-1:0] cnt_q, cnt_d;

  // Poll sequencing and timeout counting; no new poll in the cycle a byte is handed over.
  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    bv_d    = 1'b0;
    to_d    = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      PS_IDLE: begin
        if (start && !bv_q) state_d = PS_REQ;
        else                state_d = PS_IDLE;
      end
      PS_REQ: state_d = PS_SAMPLE;
      PS_SAMPLE: begin
        if (rx_flag) begin
          bv_d    = 1'b1;
          byte_d  = rx_data;
          state_d = PS_IDLE;
        end else if (start) begin
          state_d = PS_REQ;
        end else begin
          state_d = PS_IDLE;
        end
      end
      default: state_d = PS_IDLE;
    endcase
    valid_d = (state_d == PS_REQ);
    if (!tmo_en || bv_d) begin
      cnt_d = '0;
    end else if (cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
      cnt_d = '0;
      to_d  = 1'b1;
    end else begin
      cnt_d = cnt_q + TO_W'(1);
    end
  end

  // Poller state registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= PS_IDLE;
      valid_q <= 1'b0;
      byte_q  <= 8'h00;
      bv_q    <= 1'b0;
      to_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      byte_q  <= byte_d;
      bv_q    <= bv_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
    end
  end

  assign poll_valid = valid_q;
  assign rx_byte    = byte_q;
  assign byte_valid = bv_q;
  assign timeout    = to_q;
  assign idle       = (state_q == PS_IDLE);

endmodule

// File: rtl/uart_loader.sv
// Boot/download engine: parses ADDR/LEN/data/SUM frames from the UART, writes
// payload words to memory, answers with a status byte and can issue a jump.
module uart_loader
  import loader_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int TO_W           = 20
) (
  input  logic                 clk,
  input  logic                 resetn,
  loader_uart_if.master        uart,
  loader_mem_if.master         mem,
  output logic                 boot_go,
  output logic [31:0]          boot_addr,
  output logic                 busy
);

  ld_state_e   state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] len_q, len_d;
  logic [31:0] word_q, word_d;
  logic [7:0]  sum_q, sum_d;
  logic [7:0]  resp_q, resp_d;
  logic        jump_q, jump_d;
  logic        wr_q, wr_d;
  logic        memv_q, memv_d;
  logic        go_q, go_d;
  logic [31:0] baddr_q, baddr_d;
  logic        busy_q, busy_d;

  logic        poll_start_s, tmo_en_s, poll_valid_s, bv_s, to_s, p_idle_s;
  logic [7:0]  rx_byte_s;

  assign poll_start_s = (state_q == ST_IDLE) || (state_q == ST_HDR) ||
                        (state_q == ST_DATA) || (state_q == ST_SUM);
  assign tmo_en_s     = (state_q == ST_HDR) || (state_q == ST_DATA) || (state_q == ST_SUM);

  uart_byte_poller #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TO_W(TO_W)) u_poller (
    .clk        (clk),
    .resetn     (resetn),
    .start      (poll_start_s),
    .tmo_en     (tmo_en_s),
    .rx_flag    (uart.uart_rdata[RX_FLAG_BIT]),
    .rx_data    (uart.uart_rdata[RX_BYTE_MSB:RX_BYTE_LSB]),
    .poll_valid (poll_valid_s),
    .rx_byte    (rx_byte_s),
    .byte_valid (bv_s),
    .timeout    (to_s),
    .idle       (p_idle_s)
  );

  // Frame parser; jump_q remembers a LEN=0 frame because len_q also reaches 0 after data.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    len_d   = len_q;
    word_d  = word_q;
    sum_d   = sum_q;
    resp_d  = resp_q;
    jump_d  = jump_q;
    wr_d    = wr_q;
    memv_d  = memv_q;
    go_d    = 1'b0;
    baddr_d = baddr_q;
    case (state_q)
      ST_IDLE: begin
        if (bv_s) begin
          addr_d  = {24'h000000, rx_byte_s[7:2], 2'b00};
          sum_d   = rx_byte_s;
          cnt_d   = 3'd1;
          len_d   = 16'h0000;
          jump_d  = 1'b0;
          state_d = ST_HDR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HDR: begin
        if (to_s) begin
          resp_d  = RESP_TO;
          state_d = ST_RESP;
        end else if (bv_s) begin
          sum_d = sum8(sum_q, rx_byte_s);
          cnt_d = cnt_q + 3'd1;
          case (cnt_q)
            3'd1:    addr_d[15:8]  = rx_byte_s;
            3'd2:    addr_d[23:16] = rx_byte_s;
            3'd3:    addr_d[31:24] = rx_byte_s;
            3'd4:    len_d[7:0]    = rx_byte_s;
            default: begin
              len_d[15:8] = rx_byte_s;
              cnt_d       = 3'd0;
              if ({rx_byte_s, len_q[7:0]} == 16'h0000) begin
                jump_d  = 1'b1;
                state_d = ST_SUM;
              end else begin
                state_d = ST_DATA;
              end
            end
          endcase
        end else begin
          state_d = ST_HDR;
        end
      end
      ST_DATA: begin
        if (to_s) begin
          resp_d  = RESP_TO;
          state_d = ST_RESP;
        end else if (bv_s) begin
          word_d[{cnt_q[1:0], 3'b000} +: 8] = rx_byte_s;
          sum_d = sum8(sum_q, rx_byte_s);
          if (cnt_q == 3'd3) begin
            cnt_d   = 3'd0;
            memv_d  = 1'b1;
            state_d = ST_MEMW;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_MEMW: begin
        if (mem.mem_ready) begin
          memv_d  = 1'b0;
          addr_d  = addr_q + 32'd4;
          len_d   = len_q - 16'd1;
          state_d = (len_q == 16'd1) ? ST_SUM : ST_DATA;
        end else begin
          memv_d = 1'b1;
        end
      end
      ST_SUM: begin
        if (to_s) begin
          resp_d  = RESP_TO;
          state_d = ST_RESP;
        end else if (bv_s) begin
          resp_d  = (rx_byte_s == sum_q) ? RESP_OK : RESP_ERR;
          state_d = ST_RESP;
        end else begin
          state_d = ST_SUM;
        end
      end
      ST_RESP: begin
        // The write waits for any poll left over from a timeout to drain.
        if (wr_q) begin
          if (uart.uart_ready) begin
            wr_d = 1'b0;
            if ((resp_q == RESP_OK) && jump_q) begin
              go_d    = 1'b1;
              baddr_d = addr_q;
              state_d = ST_GO;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            wr_d = 1'b1;
          end
        end else if (p_idle_s) begin
          wr_d = 1'b1;
        end else begin
          wr_d = 1'b0;
        end
      end
      ST_GO:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Loader state and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      addr_q  <= 32'h0;
      len_q   <= 16'h0;
      word_q  <= 32'h0;
      sum_q   <= 8'h00;
      resp_q  <= 8'h00;
      jump_q  <= 1'b0;
      wr_q    <= 1'b0;
      memv_q  <= 1'b0;
      go_q    <= 1'b0;
      baddr_q <= 32'h0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      word_q  <= word_d;
      sum_q   <= sum_d;
      resp_q  <= resp_d;
      jump_q  <= jump_d;
      wr_q    <= wr_d;
      memv_q  <= memv_d;
      go_q    <= go_d;
      baddr_q <= baddr_d;
      busy_q  <= busy_d;
    end
  end

  assign uart.uart_valid = wr_q | poll_valid_s;
  assign uart.uart_wmask = wr_q;
  assign uart.uart_wdata = wr_q ? {24'h000000, resp_q} : 32'h0;
  assign mem.mem_valid   = memv_q;
  assign mem.mem_addr    = addr_q;
  assign mem.mem_wdata   = word_q;
  assign mem.mem_wstrb   = memv_q ? 4'hF : 4'h0;
  assign boot_go         = go_q;
  assign boot_addr       = baddr_q;
  assign busy            = busy_q;

endmodule
